// File: rtl/btn_input_conditioner.sv
// Turns raw board buttons/switches into clean controls: 2-flop sync, debounce, press strobes, mode/speed state.
// Latency raw->stable is 2+DEBOUNCE_CYCLES edges; strobes and registered outputs add one more.

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any cycle agreeing with the accepted level restarts the count.
  always_comb begin
    cnt_nxt    = '0;
    stable_nxt = stable;
    if (sync2 != stable) begin
      if (cnt == CNT_MAX) begin
        stable_nxt = sync2;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
    end
  end

  assign level = stable;

endmodule

module btn_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int MODE_INIT       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_speed,
  input  logic       sw_data,
  output logic [1:0] mode,
  output logic       S,
  output logic       ss,
  output logic       mode_pulse,
  output logic       speed_pulse
);

  localparam logic [1:0] MODE_RST = 2'(MODE_INIT);

  logic mode_level;
  logic speed_level;
  logic data_level;
  logic mode_level_q;
  logic speed_level_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mode_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode),
    .level (mode_level)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_speed_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_speed),
    .level (speed_level)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_data_db (
    .clk   (clk),
    .reset (reset),
    .raw   (sw_data),
    .level (data_level)
  );

  // Rising-edge detect on debounced levels; releases are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_level_q  <= 1'b0;
      speed_level_q <= 1'b0;
      mode_pulse    <= 1'b0;
      speed_pulse   <= 1'b0;
    end else begin
      mode_level_q  <= mode_level;
      speed_level_q <= speed_level;
      mode_pulse    <= mode_level & ~mode_level_q;
      speed_pulse   <= speed_level & ~speed_level_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode <= MODE_RST;
      S    <= 1'b0;
      ss   <= 1'b0;
    end else begin
      if (mode_pulse) begin
        mode <= mode + 2'd1;
      end
      if (speed_pulse) begin
        S <= ~S;
      end
      ss <= data_level;
    end
  end

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Directed bench for btn_input_conditioner with DEBOUNCE_CYCLES=4: strobe timing is scoreboarded by cycle number.
module tb_btn_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_speed;
  logic       sw_data;
  logic [1:0] mode;
  logic       S;
  logic       ss;
  logic       mode_pulse;
  logic       speed_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mq[$];
  int sq[$];

  btn_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .MODE_INIT(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_speed   (btn_speed),
    .sw_data     (sw_data),
    .mode        (mode),
    .S           (S),
    .ss          (ss),
    .mode_pulse  (mode_pulse),
    .speed_pulse (speed_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every strobe must match the cycle queued when its stimulus was driven.
  always @(posedge clk) begin
    #1;
    if (mode_pulse === 1'b1) begin
      if (mq.size() == 0) chk("mode_pulse_unexpected", cyc, 0);
      else chk("mode_pulse_cycle", cyc, mq.pop_front());
    end
    if (speed_pulse === 1'b1) begin
      if (sq.size() == 0) chk("speed_pulse_unexpected", cyc, 0);
      else chk("speed_pulse_cycle", cyc, sq.pop_front());
    end
  end

  initial begin
    logic [7:0] pat;
    pat = 8'b10110111;  // drive order pat[0..7] = 1,1,1,0,1,1,0,1
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_speed = 1'b0;
    sw_data = 1'b0;
    tick(2);
    chk("rst_mode", {30'd0, mode}, 0);
    chk("rst_S", {31'd0, S}, 0);
    chk("rst_ss", {31'd0, ss}, 0);
    chk("rst_mode_pulse", {31'd0, mode_pulse}, 0);
    chk("rst_speed_pulse", {31'd0, speed_pulse}, 0);
    reset = 1'b0;
    tick(3);

    // Clean press: strobe at first-sampling-edge+6, mode visible one edge later
    btn_mode = 1'b1;
    mq.push_back(cyc + 7);
    tick(7);
    chk("press_mode_before", {30'd0, mode}, 0);
    tick(1);
    chk("press_mode_after", {30'd0, mode}, 1);
    tick(12);
    chk("hold_one_step", {30'd0, mode}, 1);
    btn_mode = 1'b0;
    tick(10);
    chk("release_no_step", {30'd0, mode}, 1);

    // Four more presses: 2,3,0,1 exercises the wrap
    for (int i = 0; i < 4; i++) begin
      btn_mode = 1'b1;
      mq.push_back(cyc + 7);
      tick(10);
      chk("wrap_mode", {30'd0, mode}, (2 + i) % 4);
      btn_mode = 1'b0;
      tick(10);
    end

    // Bounce shorter than the debounce window is rejected
    for (int i = 0; i < 8; i++) begin
      btn_speed = pat[i];
      tick(1);
    end
    btn_speed = 1'b0;
    tick(12);
    chk("bounce_S_low", {31'd0, S}, 0);

    // Same bounce ending in a steady press yields one strobe
    for (int i = 0; i < 8; i++) begin
      btn_speed = pat[i];
      if (i == 7) sq.push_back(cyc + 7);
      tick(1);
    end
    tick(10);
    chk("bounce_then_hold_S", {31'd0, S}, 1);
    btn_speed = 1'b0;
    tick(10);

    // Simultaneous mode and speed presses
    btn_mode = 1'b1;
    btn_speed = 1'b1;
    mq.push_back(cyc + 7);
    sq.push_back(cyc + 7);
    tick(7);
    chk("simul_mode_before", {30'd0, mode}, 1);
    chk("simul_S_before", {31'd0, S}, 1);
    tick(1);
    chk("simul_mode_after", {30'd0, mode}, 2);
    chk("simul_S_after", {31'd0, S}, 0);
    tick(5);
    btn_mode = 1'b0;
    btn_speed = 1'b0;
    tick(10);

    btn_speed = 1'b1;
    sq.push_back(cyc + 7);
    tick(10);
    chk("speed_again_S", {31'd0, S}, 1);
    btn_speed = 1'b0;
    tick(10);

    // Data path: short pulse ignored, long level passes with 2+4+1 latency
    sw_data = 1'b1;
    tick(3);
    sw_data = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("data_short_ss", {31'd0, ss}, 0);
    end
    sw_data = 1'b1;
    tick(6);
    chk("data_rise_before", {31'd0, ss}, 0);
    tick(1);
    chk("data_rise_after", {31'd0, ss}, 1);
    tick(3);
    sw_data = 1'b0;
    tick(6);
    chk("data_fall_before", {31'd0, ss}, 1);
    tick(1);
    chk("data_fall_after", {31'd0, ss}, 0);

    // Reset mid-press; button held through release presses once after a full debounce
    chk("pre_reset_mode", {30'd0, mode}, 2);
    chk("pre_reset_S", {31'd0, S}, 1);
    btn_mode = 1'b1;
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_mode", {30'd0, mode}, 0);
    chk("async_rst_S", {31'd0, S}, 0);
    chk("async_rst_ss", {31'd0, ss}, 0);
    chk("async_rst_mode_pulse", {31'd0, mode_pulse}, 0);
    chk("async_rst_speed_pulse", {31'd0, speed_pulse}, 0);
    tick(3);
    reset = 1'b0;
    mq.push_back(cyc + 7);
    tick(7);
    chk("post_rst_mode_before", {30'd0, mode}, 0);
    tick(1);
    chk("post_rst_mode_after", {30'd0, mode}, 1);
    tick(5);
    btn_mode = 1'b0;
    tick(10);
    chk("post_rst_single_step", {30'd0, mode}, 1);

    chk("mode_pulses_missing", mq.size(), 0);
    chk("speed_pulses_missing", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
